// File: rtl/serial_rxfifo.sv
// UART receive buffer: captures received bytes into a DEPTH-entry FIFO and exposes it
// to the Z80 as a status/control register and a data register, with threshold/idle interrupts.
module serial_rxfifo #(
  parameter int DEPTH       = 16,
  parameter int ADDR_BASE   = 10,
  parameter int TIMEOUT_CYC = 2080
) (
  input  logic                     cpuclk,
  input  logic                     rst,
  inout  wire  [7:0]               data,
  input  logic                     ncs,
  input  logic                     nrd,
  input  logic                     nwr,
  input  logic [3:0]               addr,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     intr_out,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = 12;
  localparam logic [3:0]    A_STAT = 4'(ADDR_BASE);
  localparam logic [3:0]    A_DATA = 4'(ADDR_BASE + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

  // Threshold field: 0 means 1, anything above DEPTH clamps to DEPTH.
  function automatic logic [CW-1:0] sat_thr(input logic [3:0] f);
    if (f == 4'd0) return CW'(1);
    if (int'(f) > DEPTH) return CW'(DEPTH);
    return CW'(f);
  endfunction

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, r_thr;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_ie, r_ovr, r_tmo, r_got_rd, r_got_wr, r_intr;

  logic          w_sel, w_rd_act, w_wr_act, w_empty, w_full;
  logic          w_ctrl_wr, w_flush, w_pop, w_push, w_drop;
  logic [7:0]    w_status, w_head, w_rd_val;
  logic          w_unused;

  assign w_sel     = !ncs && (addr == A_STAT || addr == A_DATA);
  assign w_rd_act  = w_sel && !nrd;
  assign w_wr_act  = w_sel && !nwr;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_ctrl_wr = w_wr_act && !r_got_wr && (addr == A_STAT);
  assign w_flush   = w_ctrl_wr && data[1];
  // Pop only once the read strobe has gone away, so the CPU sees a stable head byte.
  assign w_pop     = r_got_rd && !w_rd_act && !w_empty && !w_flush;
  assign w_push    = rx_valid && !w_flush && (!w_full || w_pop);
  assign w_drop    = rx_valid && !w_flush && w_full && !w_pop;
  assign w_unused  = data[3];

  assign w_status  = {4'b0000, r_tmo, r_ovr, w_full, !w_empty};
  assign w_head    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign w_rd_val  = (addr == A_DATA) ? w_head : w_status;
  assign data      = (w_rd_act && !rst) ? w_rd_val : 8'hzz;

  assign intr_out   = r_intr;
  assign fifo_count = r_count;

  always_ff @(posedge cpuclk) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_data;
  end

  always_ff @(posedge cpuclk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_thr     <= CW'(1);
      r_tmo_cnt <= '0;
      r_ie      <= 1'b0;
      r_ovr     <= 1'b0;
      r_tmo     <= 1'b0;
      r_got_rd  <= 1'b0;
      r_got_wr  <= 1'b0;
      r_intr    <= 1'b0;
    end else begin
      r_got_wr <= w_wr_act;
      r_got_rd <= w_rd_act && (r_got_rd || addr == A_DATA);

      if (w_ctrl_wr) begin
        r_ie  <= data[0];
        r_thr <= sat_thr(data[7:4]);
      end
      if (w_ctrl_wr && data[2]) r_ovr <= 1'b0;
      if (w_drop)               r_ovr <= 1'b1;

      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_push && !w_pop)      r_count <= r_count + CW'(1);
        else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      end

      // Idle timer runs only while data sits untouched in the FIFO.
      if (w_flush || w_push || w_pop || w_empty) r_tmo_cnt <= '0;
      else if (r_tmo_cnt != TMO_MAX)             r_tmo_cnt <= r_tmo_cnt + TW'(1);

      if (w_flush || w_pop || w_empty) r_tmo <= 1'b0;
      else if (r_tmo_cnt == TMO_MAX)   r_tmo <= 1'b1;

      r_intr <= r_ie && ((r_count >= r_thr) || r_tmo);
    end
  end

endmodule

// File: tb/tb_serial_rxfifo.sv
// Directed bench for serial_rxfifo: stimulus queues expected values, a negedge monitor
// pops and compares them against the bus, interrupt and occupancy outputs.
`timescale 1ns/1ps
module tb_serial_rxfifo;

  localparam logic [3:0] A_ST = 4'd10;
  localparam logic [3:0] A_DT = 4'd11;
  localparam int K_BUS  = 0;
  localparam int K_INTR = 1;
  localparam int K_CNT  = 2;

  logic       cpuclk = 1'b0;
  logic       rst;
  wire  [7:0] data;
  logic       ncs, nrd, nwr;
  logic [3:0] addr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       intr_out;
  logic [4:0] fifo_count;
  logic       tb_oe;
  logic [7:0] tb_dout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         kind;
    logic [7:0] val;
    string      name;
  } exp_t;
  exp_t q_exp[$];

  always #5 cpuclk = ~cpuclk;

  assign data = tb_oe ? tb_dout : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data[g]);
  end

  serial_rxfifo #(.DEPTH(16), .ADDR_BASE(10), .TIMEOUT_CYC(2080)) dut (
    .cpuclk    (cpuclk),
    .rst       (rst),
    .data      (data),
    .ncs       (ncs),
    .nrd       (nrd),
    .nwr       (nwr),
    .addr      (addr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .intr_out  (intr_out),
    .fifo_count(fifo_count)
  );

  // Monitor: every expectation queued since the last active edge is checked here.
  exp_t       m_e;
  logic [7:0] m_act;
  always @(negedge cpuclk) begin
    while (q_exp.size() > 0) begin
      m_e = q_exp.pop_front();
      case (m_e.kind)
        K_BUS:   m_act = data;
        K_INTR:  m_act = {7'd0, intr_out};
        default: m_act = {3'd0, fifo_count};
      endcase
      n_checks++;
      if (m_act !== m_e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%02h expected 0x%02h", m_e.name, m_act, m_e.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge cpuclk);
      #1;
    end
  endtask

  task automatic expect_v(input int kind, input logic [7:0] v, input string nm);
    exp_t e;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    q_exp.push_back(e);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    addr = a; tb_dout = d; tb_oe = 1'b1; ncs = 1'b0; nwr = 1'b0;
    tick(1);
    ncs = 1'b1; nwr = 1'b1; tb_oe = 1'b0;
    tick(1);
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [7:0] exp, input string nm);
    addr = a; ncs = 1'b0; nrd = 1'b0;
    expect_v(K_BUS, exp, nm);
    tick(1);
    ncs = 1'b1; nrd = 1'b1;
    tick(1);
  endtask

  task automatic push(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ncs = 1'b1; nrd = 1'b1; nwr = 1'b1; addr = 4'd0;
    rx_data = 8'h00; rx_valid = 1'b0; tb_oe = 1'b0; tb_dout = 8'h00;
    tick(2);
    expect_v(K_BUS, 8'hFF, "rst_bus_released");
    expect_v(K_CNT, 8'd0, "rst_count");
    expect_v(K_INTR, 8'd0, "rst_intr");
    tick(1);
    rst = 1'b0;
    tick(1);
    bus_read(A_ST, 8'h00, "rst_status");

    // Threshold interrupt
    bus_write(A_ST, 8'h41);
    push(8'h11); push(8'h22); push(8'h33);
    bus_read(A_ST, 8'h01, "status_3");
    expect_v(K_CNT, 8'd3, "count_3");
    expect_v(K_INTR, 8'd0, "intr_below_thr");
    tick(1);
    push(8'h44);
    expect_v(K_CNT, 8'd4, "count_4");
    expect_v(K_INTR, 8'd0, "intr_not_yet");
    tick(1);
    expect_v(K_INTR, 8'd1, "intr_at_thr");
    tick(1);

    // In-order reads, then read of empty FIFO
    bus_read(A_DT, 8'h11, "rd_11");
    expect_v(K_CNT, 8'd3, "count_after_pop");
    bus_read(A_DT, 8'h22, "rd_22");
    bus_read(A_DT, 8'h33, "rd_33");
    bus_read(A_DT, 8'h44, "rd_44");
    bus_read(A_DT, 8'h00, "rd_empty");
    expect_v(K_CNT, 8'd0, "count_empty");
    expect_v(K_INTR, 8'd0, "intr_empty");
    tick(1);

    // Overflow: 17 bytes into 16 entries
    for (int i = 0; i < 17; i++) push(8'(i));
    expect_v(K_CNT, 8'd16, "count_full");
    bus_read(A_ST, 8'h07, "status_full_ovr");
    bus_write(A_ST, 8'h04);
    bus_read(A_ST, 8'h03, "status_ovr_cleared");
    expect_v(K_INTR, 8'd0, "intr_ie_off");

    // Push and pop on the same edge while full
    addr = A_DT; ncs = 1'b0; nrd = 1'b0;
    expect_v(K_BUS, 8'h00, "head_full");
    tick(1);
    ncs = 1'b1; nrd = 1'b1; rx_data = 8'hAA; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    expect_v(K_CNT, 8'd16, "count_same_edge");
    bus_read(A_ST, 8'h03, "status_same_edge");
    for (int i = 1; i < 16; i++) bus_read(A_DT, 8'(i), "drain");
    bus_read(A_DT, 8'hAA, "tail_AA");
    expect_v(K_CNT, 8'd0, "count_drained");
    tick(1);

    // Idle timeout
    bus_write(A_ST, 8'h81);
    push(8'h5A);
    tick(2081);
    expect_v(K_INTR, 8'd0, "tmo_intr_pre");
    tick(1);
    expect_v(K_INTR, 8'd1, "tmo_intr");
    bus_read(A_ST, 8'h09, "status_tmo");
    bus_read(A_DT, 8'h5A, "rd_tmo_byte");
    tick(1);
    expect_v(K_INTR, 8'd0, "tmo_intr_cleared");
    bus_read(A_ST, 8'h00, "status_tmo_cleared");

    // Flush on the same edge as a push
    push(8'h01); push(8'h02);
    expect_v(K_CNT, 8'd2, "count_pre_flush");
    addr = A_ST; tb_dout = 8'h02; tb_oe = 1'b1; ncs = 1'b0; nwr = 1'b0;
    rx_data = 8'h03; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0; ncs = 1'b1; nwr = 1'b1; tb_oe = 1'b0;
    expect_v(K_CNT, 8'd0, "count_flush");
    tick(1);
    bus_read(A_ST, 8'h00, "status_flush");

    // Threshold 0 behaves as 1
    bus_write(A_ST, 8'h01);
    push(8'h55);
    expect_v(K_INTR, 8'd0, "thr0_pre");
    tick(1);
    expect_v(K_INTR, 8'd1, "thr0_as_1");
    tick(1);

    // Reset in the middle of a data read
    push(8'h61); push(8'h62);
    addr = A_DT; ncs = 1'b0; nrd = 1'b0;
    expect_v(K_BUS, 8'h55, "rd_before_rst");
    tick(1);
    rst = 1'b1;
    expect_v(K_BUS, 8'hFF, "rst_mid_bus_released");
    expect_v(K_CNT, 8'd0, "rst_mid_count");
    expect_v(K_INTR, 8'd0, "rst_mid_intr");
    tick(1);
    ncs = 1'b1; nrd = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    expect_v(K_CNT, 8'd0, "post_rst_count");
    expect_v(K_INTR, 8'd0, "post_rst_intr");
    bus_read(A_ST, 8'h00, "post_rst_status");
    push(8'h77);
    bus_read(A_DT, 8'h77, "post_rst_rd");
    expect_v(K_CNT, 8'd0, "post_rst_count_end");
    tick(2);

    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drained: got %0d pending expected 0", q_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
